// File: rtl/alu16_seq.sv
// ---------------------------------------------------------------------------
// alu16_seq
//
// Area-reduced 16-bit ALU. A single 8-bit ALU slice (alu8) is shared across
// two cycles, one per byte, instead of chaining two slices. Operands are
// accepted over a valid/ready handshake. The result comes back over a
// second valid/ready handshake.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand request valid
//   in_ready   out  1   block can accept a request this cycle
//   A, B       in   16  operands
//   Op         in   3   opcode
//                       000 ADD, 001 SUB, 010 AND, 011 OR,
//                       100 XOR, 101 SHL, 110 SHR, 111 NOT A
//   Cin        in   1   carry / borrow / shift-in
//   out_valid  out  1   Y/Cout/Z valid
//   out_ready  in   1   consumer accepts result
//   Y          out  16  result
//   Cout       out  1   carry out / shifted-out bit
//   Z          out  1   1 when Y == 0
//
// Parameter
//   ALLOW_B2B  1: a new request may be accepted in DONE on the same edge
//                 that the result is taken (3-clock throughput)
//              0: requests are accepted only in IDLE (4-clock throughput)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu8 -- purely combinational 8-bit slice shared by both halves.
//   a, b   in  8  operand bytes
//   op     in  3  opcode (same encoding as the 16-bit top)
//   cin    in  1  carry / shift-in
//   y      out 8  result byte
//   cout   out 1  carry out or shifted-out bit (0 for logic ops)
// ---------------------------------------------------------------------------
module alu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    input  logic       cin,
    output logic [7:0] y,
    output logic       cout
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // One slice of the datapath. Subtraction is A + ~B + Cin, so a carry
    // out of 1 means "no borrow". Logic ops never produce a carry, which
    // also means the second half of a logic op sees a harmless 0 carry-in.
    always_comb begin
        y    = 8'h00;
        cout = 1'b0;
        case (op)
            OP_ADD: {cout, y} = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            OP_SUB: {cout, y} = {1'b0, a} + {1'b0, ~b} + {8'h00, cin};
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: begin
                y    = {a[6:0], cin};
                cout = a[7];
            end
            OP_SHR: begin
                y    = {cin, a[7:1]};
                cout = a[0];
            end
            OP_NOT: y = ~a;
            default: begin
                y    = 8'h00;
                cout = 1'b0;
            end
        endcase
    end

endmodule

module alu16_seq #(
    parameter bit ALLOW_B2B = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  Op,
    input  logic        Cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Y,
    output logic        Cout,
    output logic        Z
);

    localparam logic [2:0] OP_SHR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [2:0]  op_q;
    logic        cin_q;

    logic [7:0]  half_q;
    logic        carry_q;

    logic [15:0] y_q;
    logic        cout_q;
    logic        z_q;

    logic        accept;
    logic        is_shr;
    logic        hi_phase;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_y;
    logic        alu_cout;
    logic [15:0] result;

    // in_ready is combinational so the producer learns in the same cycle
    // whether the DONE slot can be recycled. It is held low during reset
    // so nothing is accepted while the block is being cleared.
    assign in_ready  = !rst &&
                       ((state == S_IDLE) ||
                        (ALLOW_B2B && (state == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);

    assign Y    = y_q;
    assign Cout = cout_q;
    assign Z    = z_q;

    // State register. Reset drops any in-flight operation on the floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. FIRST and SECOND always take exactly one cycle each.
    // DONE waits for the consumer. If a new request is accepted on the same
    // edge as the result handshake, the next op starts directly in FIRST.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_FIRST;
                end
            end
            S_FIRST:  next_state = S_SECOND;
            S_SECOND: next_state = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    next_state = accept ? S_FIRST : S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Byte sequencing for the shared slice. Most ops run low byte then high
    // byte, so the low carry (or SHL's A[7]) ripples upward. SHR runs the
    // other way. The high byte goes first with the external Cin entering
    // bit 15. Its shifted-out A[8] then becomes the low byte's shift-in.
    assign is_shr   = (op_q == OP_SHR);
    assign hi_phase = (state == S_FIRST) ? is_shr : !is_shr;

    always_comb begin
        alu_a   = a_q[7:0];
        alu_b   = b_q[7:0];
        alu_cin = carry_q;
        if (hi_phase) begin
            alu_a = a_q[15:8];
            alu_b = b_q[15:8];
        end
        if (state == S_FIRST) begin
            alu_cin = cin_q;
        end
    end

    alu8 u_alu8 (
        .a    (alu_a),
        .b    (alu_b),
        .op   (op_q),
        .cin  (alu_cin),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // The slice output in SECOND is the half that was not stored in FIRST.
    // Its carry is the 16-bit carry for every op:
    //   ADD/SUB -> high-half carry
    //   SHL     -> A[15]
    //   SHR     -> A[0]
    //   logic   -> 0
    assign result = is_shr ? {half_q, alu_y} : {alu_y, half_q};

    // Operand capture. Only the accepting edge loads these registers, so
    // later changes on A/B/Op/Cin cannot disturb an operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= 16'h0000;
            b_q   <= 16'h0000;
            op_q  <= 3'b000;
            cin_q <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= Op;
            cin_q <= Cin;
        end
    end

    // Intermediate half-result and carry produced in FIRST and consumed in
    // SECOND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q  <= 8'h00;
            carry_q <= 1'b0;
        end else if (state == S_FIRST) begin
            half_q  <= alu_y;
            carry_q <= alu_cout;
        end
    end

    // Result registers. They are written only at the end of SECOND, so
    // they stay rock-steady for as long as DONE is back-pressured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= 16'h0000;
            cout_q <= 1'b0;
            z_q    <= 1'b0;
        end else if (state == S_SECOND) begin
            y_q    <= result;
            cout_q <= alu_cout;
            z_q    <= (result == 16'h0000);
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
// ---------------------------------------------------------------------------
// tb_alu16_seq
//
// Directed bench for alu16_seq. The stimulus process pushes the
// hand-computed result of every request into a scoreboard queue. A
// separate monitor pops the queue whenever the DUT hands over a result.
// A second instance with ALLOW_B2B=0 is used to observe the extra idle
// cycle between operations.
// ---------------------------------------------------------------------------
module tb_alu16_seq;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef struct {
        string       name;
        logic [15:0] y;
        logic        cout;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        cout;
    logic        z;

    logic        n_in_valid;
    logic        n_in_ready;
    logic [15:0] n_a;
    logic [15:0] n_b;
    logic [2:0]  n_op;
    logic        n_cin;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [15:0] n_y;
    logic        n_cout;
    logic        n_z;

    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_acc[$];
    int   acc[12];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    alu16_seq #(.ALLOW_B2B(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Op        (op),
        .Cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (y),
        .Cout      (cout),
        .Z         (z)
    );

    alu16_seq #(.ALLOW_B2B(1'b0)) dut_nob2b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .A         (n_a),
        .B         (n_b),
        .Op        (n_op),
        .Cin       (n_cin),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .Y         (n_y),
        .Cout      (n_cout),
        .Z         (n_z)
    );

    // Single comparison point: every check passes through here and steps
    // the counters reported in the summary line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one request and wait (bounded) for the accepting edge.
    // Returns one time unit after that edge, with in_valid dropped and
    // the operand inputs scrambled.
    task automatic applyStimulus(input string name, input logic [15:0] a_v,
                                 input logic [15:0] b_v, input logic [2:0] op_v,
                                 input logic cin_v, input logic [15:0] ey,
                                 input logic ec, input logic ez,
                                 input bit expect_out, output int acc_cycle);
        exp_t e;
        in_valid = 1'b1;
        a        = a_v;
        b        = b_v;
        op       = op_v;
        cin      = cin_v;
        if (expect_out) begin
            e.name = name;
            e.y    = ey;
            e.cout = ec;
            e.z    = ez;
            sb_q.push_back(e);
        end
        acc_cycle = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cycle = cycle;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (acc_cycle < 0) begin
            checkOutput({name, " accept timeout"}, {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        a        = ~a_v;
        b        = ~b_v;
        op       = ~op_v;
        cin      = ~cin_v;
    endtask

    // Result monitor: a handshake at the coming edge consumes one
    // scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput({mon_e.name, " Y"},    {16'b0, y},    {16'b0, mon_e.y});
                checkOutput({mon_e.name, " Cout"}, {31'b0, cout}, {31'b0, mon_e.cout});
                checkOutput({mon_e.name, " Z"},    {31'b0, z},    {31'b0, mon_e.z});
            end
        end
    end

    // Accept log for the no-back-to-back instance.
    always @(negedge clk) begin
        if (!rst && n_in_valid && n_in_ready) begin
            n_acc.push_back(cycle);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dummy;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = 16'h0000;
        b           = 16'h0000;
        op          = OP_ADD;
        cin         = 1'b0;
        out_ready   = 1'b1;
        n_in_valid  = 1'b0;
        n_a         = 16'h0001;
        n_b         = 16'h0002;
        n_op        = OP_ADD;
        n_cin       = 1'b0;
        n_out_ready = 1'b1;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset Y",         {16'b0, y},         32'd0);
        checkOutput("reset Cout",      {31'b0, cout},      32'd0);
        checkOutput("reset Z",         {31'b0, z},         32'd0);
        checkOutput("reset in_ready",  {31'b0, in_ready},  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle in_ready", {31'b0, in_ready}, 32'd1);

        $display("[TB] ALLOW_B2B=0 throughput");
        n_in_valid = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        checkOutput("nob2b accept count >= 3", {31'b0, n_acc.size() >= 3}, 32'd1);
        if (n_acc.size() >= 3) begin
            checkOutput("nob2b gap 1", n_acc[1] - n_acc[0], 32'd4);
            checkOutput("nob2b gap 2", n_acc[2] - n_acc[1], 32'd4);
        end
        checkOutput("nob2b Y", {16'b0, n_y}, 32'h0003);

        $display("[TB] ADD with latency check");
        applyStimulus("ADD 00FF+1", 16'h00FF, 16'h0001, OP_ADD, 1'b0,
                      16'h0100, 1'b0, 1'b0, 1'b1, dummy);
        @(negedge clk);
        checkOutput("latency FIRST", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latency SECOND", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latency DONE", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back directed vectors");
        applyStimulus("SUB 0-1",     16'h0000, 16'h0001, OP_SUB, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, acc[0]);
        applyStimulus("XOR FFFF",    16'hFFFF, 16'hFFFF, OP_XOR, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, acc[1]);
        applyStimulus("SHR 0100",    16'h0100, 16'h0000, OP_SHR, 1'b1, 16'h8080, 1'b0, 1'b0, 1'b1, acc[2]);
        applyStimulus("SHL 8080",    16'h8080, 16'h0000, OP_SHL, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1, acc[3]);
        applyStimulus("AND",         16'h0F0F, 16'h00FF, OP_AND, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b1, acc[4]);
        applyStimulus("OR",          16'h0F00, 16'h00F0, OP_OR,  1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b1, acc[5]);
        applyStimulus("NOT",         16'h00F0, 16'h1234, OP_NOT, 1'b1, 16'hFF0F, 1'b0, 1'b0, 1'b1, acc[6]);
        applyStimulus("ADD wrap",    16'hFFFF, 16'h0001, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc[7]);
        applyStimulus("SUB 5-3",     16'h0005, 16'h0003, OP_SUB, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, acc[8]);
        applyStimulus("SHR 0001",    16'h0001, 16'h0000, OP_SHR, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc[9]);
        applyStimulus("SHL 4000",    16'h4000, 16'h0000, OP_SHL, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, acc[10]);
        applyStimulus("ADD cin",     16'h1234, 16'h4321, OP_ADD, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1, acc[11]);
        checkOutput("b2b gap 1", acc[1] - acc[0], 32'd3);
        checkOutput("b2b gap 2", acc[2] - acc[1], 32'd3);
        checkOutput("b2b gap 3", acc[3] - acc[2], 32'd3);

        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus("ADD backpressure", 16'h7FFF, 16'h0001, OP_ADD, 1'b0,
                      16'h8000, 1'b0, 1'b0, 1'b1, dummy);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 16'h0000;
        b        = 16'h0000;
        op       = OP_ADD;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold Y",         {16'b0, y},         32'h8000);
            checkOutput("hold in_ready",  {31'b0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("[TB] reset during SECOND");
        applyStimulus("ADD discarded", 16'h1111, 16'h2222, OP_ADD, 1'b0,
                      16'h3333, 1'b0, 1'b0, 1'b0, dummy);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid-op reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid-op reset Y",         {16'b0, y},         32'd0);
        checkOutput("mid-op reset Cout",      {31'b0, cout},      32'd0);
        checkOutput("mid-op reset in_ready",  {31'b0, in_ready},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("no output after reset", {31'b0, out_valid}, 32'd0);
        applyStimulus("ADD 1+1", 16'h0001, 16'h0001, OP_ADD, 1'b0,
                      16'h0002, 1'b0, 1'b0, 1'b1, dummy);

        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("scoreboard drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
